game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 50000: cycles the synchronised button must hold a stable value before the debounced level changes.
REQ-002 Parameter FRESH_HIGH, default 8: cycles fresh stays high after each frame start.
REQ-003 Parameter SCORE_DIV, default 6: RUN frames per score increment.
REQ-004 Parameter OVER_HOLD, default 60: OVER frames during which start presses are ignored.
REQ-005 clk  in  1  system clock; the only clock; all logic on posedge clk.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 vsync  in  1  VGA vertical sync, synchronous to clk; rising edge = frame start.
REQ-008 btn_start  in  1  raw start/jump button, asynchronous, active-high.
REQ-009 collision  in  1  dino/obstacle overlap flag, synchronous to clk.
REQ-010 game_status  out  1  high only in RUN; drives the ground scroller's game_status.
REQ-011 fresh  out  1  per-frame strobe; its falling edge advances the ground scroller once per frame.
REQ-012 state  out  2  IDLE=0, RUN=1, OVER=2.
REQ-013 score  out  14  current score, binary.
REQ-014 high_score  out  14  best score since reset, binary.

Function
REQ-015 Frame tick: a one-cycle internal pulse on the cycle after vsync is sampled 1 having been 0 on the previous cycle.
REQ-016 fresh rises the cycle after the frame tick and stays high exactly FRESH_HIGH cycles; a frame tick while fresh is high restarts the count, so fresh stays high.
REQ-017 Button path: 2-flop synchroniser, then debounce counter; the level changes only after DEB_CYCLES consecutive equal samples; a 0->1 debounced transition emits a one-cycle press pulse.
REQ-018 FSM IDLE -> RUN on press; on entry, score is cleared to 0 and the frame counter is cleared.
REQ-019 FSM RUN -> OVER on any cycle with collision=1; collision takes priority over a same-cycle press.
REQ-020 FSM OVER -> RUN on press, but only after OVER_HOLD frame ticks have elapsed in OVER; earlier presses are dropped, not queued.
REQ-021 collision is ignored in IDLE and OVER.
REQ-022 In RUN, a frame-tick counter counts to SCORE_DIV; when it reaches SCORE_DIV it wraps to 0 and score increments.
REQ-023 score saturates at 9999 and holds there.
REQ-024 On the RUN->OVER transition cycle, high_score is loaded with score if score > high_score; otherwise it is unchanged.
REQ-025 In OVER, score holds its final value until the next RUN entry.
REQ-026 game_status is registered: it rises one cycle after the state register shows RUN and falls one cycle after it leaves RUN.
REQ-027 Illegal state encoding 3 returns to IDLE on the next cycle.

Reset
REQ-028 On rst_n=0, the following are forced immediately, independent of clk: state=IDLE, game_status=0, fresh=0, score=0, high_score=0, all counters=0, synchroniser flops=0, debounced level=0.
REQ-029 A reset asserted during RUN or OVER aborts the game with no high_score update; after release, the block waits in IDLE for a new press.

Structure
REQ-030 Package game_pkg holds the state encoding constants, SCORE_MAX=9999, and the 14-bit score width.
REQ-031 Synchroniser and debounce logic live in sub-module btn_debounce (ports clk, rst_n, btn_raw, level, press), parameterised by DEB_CYCLES.
REQ-032 Fresh generation, FSM, and score logic stay in game_ctrl.

Verification
REQ-033 Use DEB_CYCLES=4, FRESH_HIGH=3, SCORE_DIV=2, OVER_HOLD=3 in all directed tests.
REQ-034 Fresh test: in IDLE, vsync pulses every 20 cycles -> fresh high for exactly 3 cycles starting 2 cycles after each vsync rise, and game_status=0.
REQ-035 Debounce test: 2-cycle button glitch -> no state change; then 6-cycle hold -> state=RUN, game_status=1 one cycle later, score=0.
REQ-036 Score test: 10 frames in RUN -> score=5; force an internal score of 9998 and run 4 frames -> score=9999, held.
REQ-037 Collision test: collision and press in the same RUN cycle with score=7 and high_score=3 -> state=OVER, high_score=7, game_status=0; a second game reaching 4 then colliding -> high_score stays 7.
REQ-038 Hold-off test: press after 1 OVER frame -> stays OVER; press after 3 frames -> RUN with score=0; rst_n=0 mid-RUN -> all outputs 0 immediately, then IDLE.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game controller: state encoding and score limits.
package game_pkg;

  localparam int unsigned SCORE_W = 14;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StOver = 2'd2
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for a raw button.
// Emits a one-cycle press pulse on each debounced 0->1 transition.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      // DEB_CYCLES consecutive samples disagreed with the level: accept the new value.
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/game_ctrl.sv
// Game controller: frame strobe generation, IDLE/RUN/OVER state machine,
// score counting with saturation and high-score tracking.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 50000,
  parameter int unsigned FRESH_HIGH = 8,
  parameter int unsigned SCORE_DIV  = 6,
  parameter int unsigned OVER_HOLD  = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               btn_start,
  input  logic               collision,
  output logic               game_status,
  output logic               fresh,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score
);

  localparam int unsigned FW = $clog2(FRESH_HIGH + 1);
  localparam int unsigned DW = $clog2(SCORE_DIV + 1);
  localparam int unsigned OW = $clog2(OVER_HOLD + 1);

  logic               btn_level;
  logic               press;
  logic               vsync_q;
  logic               tick_q;
  logic [FW-1:0]      fresh_cnt_q, fresh_cnt_d;
  state_e             state_q, state_d;
  logic               game_status_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [DW-1:0]      frame_q, frame_d;
  logic [OW-1:0]      over_q, over_d;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_start),
    .level  (btn_level),
    .press  (press)
  );

  // A new frame tick reloads the count, so overlapping frames keep fresh high.
  always_comb begin
    fresh_cnt_d = fresh_cnt_q;
    if (tick_q) begin
      fresh_cnt_d = FW'(FRESH_HIGH);
    end else if (fresh_cnt_q != '0) begin
      fresh_cnt_d = fresh_cnt_q - FW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    high_d  = high_q;
    frame_d = frame_q;
    over_d  = over_q;
    case (state_q)
      StIdle: begin
        if (press) begin
          state_d = StRun;
          score_d = '0;
          frame_d = '0;
        end
      end
      StRun: begin
        // Collision wins over a same-cycle press or frame tick.
        if (collision) begin
          state_d = StOver;
          over_d  = '0;
          if (score_q > high_q) begin
            high_d = score_q;
          end
        end else if (tick_q) begin
          if (frame_q == DW'(SCORE_DIV - 1)) begin
            frame_d = '0;
            if (score_q != SCORE_MAX) begin
              score_d = score_q + SCORE_W'(1);
            end
          end else begin
            frame_d = frame_q + DW'(1);
          end
        end
      end
      StOver: begin
        if (press && (over_q >= OW'(OVER_HOLD))) begin
          state_d = StRun;
          score_d = '0;
          frame_d = '0;
        end else if (tick_q && (over_q < OW'(OVER_HOLD))) begin
          over_d = over_q + OW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q       <= 1'b0;
      tick_q        <= 1'b0;
      fresh_cnt_q   <= '0;
      state_q       <= StIdle;
      game_status_q <= 1'b0;
      score_q       <= '0;
      high_q        <= '0;
      frame_q       <= '0;
      over_q        <= '0;
    end else begin
      vsync_q       <= vsync;
      tick_q        <= vsync & ~vsync_q;
      fresh_cnt_q   <= fresh_cnt_d;
      state_q       <= state_d;
      game_status_q <= (state_q == StRun);
      score_q       <= score_d;
      high_q        <= high_d;
      frame_q       <= frame_d;
      over_q        <= over_d;
    end
  end

  assign fresh       = (fresh_cnt_q != '0);
  assign game_status = game_status_q;
  assign state       = state_q;
  assign score       = score_q;
  assign high_score  = high_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl with scoreboard queues for fresh and score.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic        btn_start;
  logic        collision;
  logic        game_status;
  logic        fresh;
  logic [1:0]  state;
  logic [13:0] score;
  logic [13:0] high_score;

  int errors = 0;
  int checks = 0;
  int m_score;
  int m_fcnt;
  int exp_q[$];
  bit fexp_q[$];

  always #5 clk = ~clk;

  game_ctrl #(
    .DEB_CYCLES(4),
    .FRESH_HIGH(3),
    .SCORE_DIV (2),
    .OVER_HOLD (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .btn_start  (btn_start),
    .collision  (collision),
    .game_status(game_status),
    .fresh      (fresh),
    .state      (state),
    .score      (score),
    .high_score (high_score)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    vsync = 1'b1;
    step(1);
    vsync = 1'b0;
    step(3);
  endtask

  // Clean 6-cycle press, then time for the debounced level to fall again.
  task automatic press_btn();
    btn_start = 1'b1;
    step(6);
    btn_start = 1'b0;
    step(7);
  endtask

  // Frames in RUN: the model predicts the score and the scoreboard checks it.
  task automatic run_frames(input int n, input string tag);
    int exp;
    for (int i = 0; i < n; i++) begin
      m_fcnt++;
      if (m_fcnt == 2) begin
        m_fcnt = 0;
        if (m_score < 9999) m_score++;
      end
      exp_q.push_back(m_score);
      frame();
      exp = exp_q.pop_front();
      checks++;
      if (score !== 14'(exp)) begin
        errors++;
        $display("FAIL %s frame %0d: score=%0d expected %0d", tag, i, score, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vsync = 1'b0; btn_start = 1'b0; collision = 1'b0;
    #1;
    checks++;
    if ({state, game_status, fresh, score, high_score} !== 31'd0) begin
      errors++;
      $display("FAIL reset: outputs=%h expected 0", {state, game_status, fresh, score, high_score});
    end
    step(1);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_fresh();
    bit e;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 20; c++) begin
        if (c == 0) begin
          for (int k = 0; k < 20; k++) fexp_q.push_back(k >= 2 && k <= 4);
        end
        e = fexp_q.pop_front();
        checks++;
        if (fresh !== e || game_status !== 1'b0) begin
          errors++;
          $display("FAIL fresh p%0d c%0d: fresh=%b gs=%b expected fresh=%b gs=0",
                   p, c, fresh, game_status, e);
        end
        vsync = (c < 2);
        step(1);
      end
    end
  endtask

  task automatic test_debounce();
    btn_start = 1'b1;
    step(2);
    btn_start = 1'b0;
    step(10);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL glitch: state=%0d expected 0", state);
    end
    btn_start = 1'b1;
    step(6);
    btn_start = 1'b0;
    step(1);
    checks++;
    if (state !== 2'd1 || score !== 14'd0 || game_status !== 1'b0) begin
      errors++;
      $display("FAIL debounce press: state=%0d score=%0d gs=%b expected 1 0 0",
               state, score, game_status);
    end
    step(1);
    checks++;
    if (game_status !== 1'b1) begin
      errors++;
      $display("FAIL game_status rise: gs=%b expected 1", game_status);
    end
    step(6);
    m_score = 0;
    m_fcnt  = 0;
  endtask

  task automatic test_score();
    run_frames(10, "score");
    force dut.score_q = 14'd9998;
    step(1);
    release dut.score_q;
    m_score = 9998;
    run_frames(6, "saturate");
  endtask

  task automatic test_reset_mid_run();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state, game_status, fresh, score, high_score} !== 31'd0) begin
      errors++;
      $display("FAIL mid-run reset: outputs=%h expected 0",
               {state, game_status, fresh, score, high_score});
    end
    step(1);
    rst_n = 1'b1;
    frame();
    frame();
    checks++;
    if (state !== 2'd0 || score !== 14'd0 || game_status !== 1'b0) begin
      errors++;
      $display("FAIL after reset: state=%0d score=%0d gs=%b expected 0 0 0",
               state, score, game_status);
    end
  endtask

  task automatic collide(input logic [13:0] exp_high, input string tag);
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    checks++;
    if (state !== 2'd2 || high_score !== exp_high || score !== 14'(m_score)) begin
      errors++;
      $display("FAIL %s: state=%0d high=%0d score=%0d expected 2 %0d %0d",
               tag, state, high_score, score, exp_high, m_score);
    end
    step(1);
  endtask

  task automatic test_collision_holdoff();
    press_btn();
    m_score = 0; m_fcnt = 0;
    run_frames(6, "game1");
    collide(14'd3, "collide game1");
    frame();
    press_btn();
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL early press: state=%0d expected 2", state);
    end
    frame();
    frame();
    press_btn();
    checks++;
    if (state !== 2'd1 || score !== 14'd0) begin
      errors++;
      $display("FAIL holdoff press: state=%0d score=%0d expected 1 0", state, score);
    end
    m_score = 0; m_fcnt = 0;
    run_frames(14, "game2");
    // Debounced press pulse and collision land on the same clock edge.
    btn_start = 1'b1;
    step(6);
    btn_start = 1'b0;
    collide(14'd7, "collide+press");
    checks++;
    if (game_status !== 1'b0) begin
      errors++;
      $display("FAIL game_status fall: gs=%b expected 0", game_status);
    end
    step(6);
    frame(); frame(); frame();
    press_btn();
    m_score = 0; m_fcnt = 0;
    run_frames(8, "game3");
    collide(14'd7, "collide lower score");
  endtask

  initial begin
    test_reset();
    test_fresh();
    test_debounce();
    test_score();
    test_reset_mid_run();
    test_collision_holdoff();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
